// File: rtl/lc3_pkg.sv
// Shared constants and types for the LC-3 memory controller: word width,
// memory-mapped device addresses and the access sequencer state encoding.
package lc3_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [15:0] IO_BASE   = 16'hFE00;
  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
  localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } state_e;

  function automatic logic is_io(input logic [15:0] addr);
    return addr >= IO_BASE;
  endfunction

endpackage

// File: rtl/lc3_io_regs.sv
// LC-3 memory-mapped device registers (KBSR/KBDR/DSR/DDR/MCR) with the
// keyboard and display valid/ready handshakes.
module lc3_io_regs
  import lc3_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [15:0]       addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  input  logic              kb_valid,
  input  logic [7:0]        kb_data,
  output logic              kb_ready,
  output logic              dd_valid,
  output logic [7:0]        dd_data,
  input  logic              dd_ready,
  output logic              kb_irq,
  output logic              mcr_run
);

  logic       kb_full_q, kb_full_d;
  logic       kb_ie_q, kb_ie_d;
  logic [7:0] kbdr_q, kbdr_d;
  logic       dd_valid_q, dd_valid_d;
  logic [7:0] dd_data_q, dd_data_d;
  logic       mcr_run_q, mcr_run_d;

  logic sel_kbsr, sel_kbdr, sel_dsr, sel_ddr, sel_mcr;
  logic unused_wdata;

  assign sel_kbsr = (addr == ADDR_KBSR);
  assign sel_kbdr = (addr == ADDR_KBDR);
  assign sel_dsr  = (addr == ADDR_DSR);
  assign sel_ddr  = (addr == ADDR_DDR);
  assign sel_mcr  = (addr == ADDR_MCR);

  assign unused_wdata = ^wdata;

  always_comb begin
    kb_full_d  = kb_full_q;
    kb_ie_d    = kb_ie_q;
    kbdr_d     = kbdr_q;
    dd_valid_d = dd_valid_q;
    dd_data_d  = dd_data_q;
    mcr_run_d  = mcr_run_q;

    if (rd_en && sel_kbdr) kb_full_d = 1'b0;
    // Acceptance is gated on the registered full flag, so a key offered while
    // KBDR is being read waits one cycle.
    if (kb_valid && !kb_full_q) begin
      kb_full_d = 1'b1;
      kbdr_d    = kb_data;
    end
    if (wr_en && sel_kbsr) kb_ie_d = wdata[14];

    if (dd_valid_q && dd_ready) dd_valid_d = 1'b0;
    if (wr_en && sel_ddr && !dd_valid_q) begin
      dd_valid_d = 1'b1;
      dd_data_d  = wdata[7:0];
    end

    if (wr_en && sel_mcr) mcr_run_d = wdata[15];
  end

  always_comb begin
    rdata = '0;
    if (sel_kbsr)      rdata = {kb_full_q, kb_ie_q, 14'b0};
    else if (sel_kbdr) rdata = {8'h00, kbdr_q};
    else if (sel_dsr)  rdata = {!dd_valid_q, 15'b0};
    else if (sel_ddr)  rdata = {8'h00, dd_data_q};
    else if (sel_mcr)  rdata = {mcr_run_q, 15'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_full_q  <= 1'b0;
      kb_ie_q    <= 1'b0;
      kbdr_q     <= '0;
      dd_valid_q <= 1'b0;
      dd_data_q  <= '0;
      mcr_run_q  <= 1'b1;
    end else begin
      kb_full_q  <= kb_full_d;
      kb_ie_q    <= kb_ie_d;
      kbdr_q     <= kbdr_d;
      dd_valid_q <= dd_valid_d;
      dd_data_q  <= dd_data_d;
      mcr_run_q  <= mcr_run_d;
    end
  end

  assign kb_ready = !kb_full_q;
  assign kb_irq   = kb_full_q & kb_ie_q;
  assign dd_valid = dd_valid_q;
  assign dd_data  = dd_data_q;
  assign mcr_run  = mcr_run_q;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: sequences port-A BRAM accesses around the RAM's
// registered read latency and routes the I/O page to the device registers.
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter int unsigned ADDR = 12,
  parameter int unsigned DATA = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [15:0]     cpu_addr,
  input  logic [DATA-1:0] cpu_wdata,
  output logic [DATA-1:0] cpu_rdata,
  output logic            cpu_ready,
  output logic            bram_wr,
  output logic [ADDR-1:0] bram_addr,
  output logic [DATA-1:0] bram_din,
  input  logic [DATA-1:0] bram_dout,
  input  logic            kb_valid,
  input  logic [7:0]      kb_data,
  output logic            kb_ready,
  output logic            dd_valid,
  output logic [7:0]      dd_data,
  input  logic            dd_ready,
  output logic            kb_irq,
  output logic            mcr_run
);

  state_e          state_q, state_d;
  logic            bram_wr_q, bram_wr_d;
  logic [ADDR-1:0] bram_addr_q, bram_addr_d;
  logic [DATA-1:0] bram_din_q, bram_din_d;
  logic [DATA-1:0] rdata_q, rdata_d;
  logic            rd_q, rd_d;
  logic            io_rd, io_wr;
  logic [DATA-1:0] io_rdata;

  always_comb begin
    state_d     = state_q;
    bram_wr_d   = bram_wr_q;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    rdata_d     = rdata_q;
    rd_d        = rd_q;
    io_rd       = 1'b0;
    io_wr       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          if (is_io(cpu_addr)) begin
            io_rd   = !cpu_we;
            io_wr   = cpu_we;
            if (!cpu_we) rdata_d = io_rdata;
            state_d = StDone;
          end else begin
            bram_addr_d = cpu_addr[ADDR-1:0];
            bram_din_d  = cpu_wdata;
            bram_wr_d   = cpu_we;
            rd_d        = !cpu_we;
            state_d     = StAcc;
          end
        end
      end
      StAcc: begin
        bram_wr_d = 1'b0;
        state_d   = StWait;
      end
      StWait: begin
        if (rd_q) rdata_d = bram_dout;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bram_wr_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      rdata_q     <= '0;
      rd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bram_wr_q   <= bram_wr_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      rdata_q     <= rdata_d;
      rd_q        <= rd_d;
    end
  end

  assign cpu_ready = (state_q == StDone);
  assign cpu_rdata = rdata_q;
  assign bram_wr   = bram_wr_q;
  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;

  lc3_io_regs u_io_regs (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (io_rd),
    .wr_en    (io_wr),
    .addr     (cpu_addr),
    .wdata    (cpu_wdata),
    .rdata    (io_rdata),
    .kb_valid (kb_valid),
    .kb_data  (kb_data),
    .kb_ready (kb_ready),
    .dd_valid (dd_valid),
    .dd_data  (dd_data),
    .dd_ready (dd_ready),
    .kb_irq   (kb_irq),
    .mcr_run  (mcr_run)
  );

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed self-checking bench for lc3_mem_ctrl with a behavioural
// one-cycle-latency BRAM model on port A.
module tb_lc3_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        bram_wr;
  logic [11:0] bram_addr;
  logic [15:0] bram_din;
  logic [15:0] bram_dout;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        kb_ready;
  logic        dd_valid;
  logic [7:0]  dd_data;
  logic        dd_ready;
  logic        kb_irq;
  logic        mcr_run;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [4096];

  always #5 clk = ~clk;

  // Read-first BRAM: dout reflects the address presented on the previous edge.
  always @(posedge clk) begin
    if (bram_wr) mem[bram_addr] <= bram_din;
    bram_dout <= mem[bram_addr];
  end

  lc3_mem_ctrl #(.ADDR(12), .DATA(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .bram_wr   (bram_wr),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_dout (bram_dout),
    .kb_valid  (kb_valid),
    .kb_data   (kb_data),
    .kb_ready  (kb_ready),
    .dd_valid  (dd_valid),
    .dd_data   (dd_data),
    .dd_ready  (dd_ready),
    .kb_irq    (kb_irq),
    .mcr_run   (mcr_run)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Request sampled at edge N; views are taken on the following negedges.
  task automatic bram_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [15:0] exp, input string tag);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    check({tag, "_wr_n1"}, bram_wr, we);
    check({tag, "_addr_n1"}, bram_addr, {4'h0, addr[11:0]});
    check({tag, "_rdy_n1"}, cpu_ready, 1'b0);
    @(negedge clk);
    check({tag, "_wr_n2"}, bram_wr, 1'b0);
    check({tag, "_rdy_n2"}, cpu_ready, 1'b0);
    @(negedge clk);
    check({tag, "_rdy_n3"}, cpu_ready, 1'b1);
    if (!we) check({tag, "_data"}, cpu_rdata, exp);
    cpu_req = 1'b0;
    @(negedge clk);
    check({tag, "_rdy_n4"}, cpu_ready, 1'b0);
  endtask

  task automatic io_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] exp, input string tag);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    check({tag, "_rdy_n1"}, cpu_ready, 1'b1);
    if (!we) check({tag, "_data"}, cpu_rdata, exp);
    cpu_req = 1'b0;
    @(negedge clk);
    check({tag, "_rdy_n2"}, cpu_ready, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    kb_valid = 1'b0; kb_data = '0; dd_ready = 1'b0;

    #12;
    check("rst_ready", cpu_ready, 1'b0);
    check("rst_rdata", cpu_rdata, 16'h0000);
    check("rst_bram_wr", bram_wr, 1'b0);
    check("rst_bram_addr", bram_addr, 16'h0000);
    check("rst_bram_din", bram_din, 16'h0000);
    check("rst_kb_ready", kb_ready, 1'b1);
    check("rst_dd_valid", dd_valid, 1'b0);
    check("rst_dd_data", dd_data, 16'h0000);
    check("rst_mcr_run", mcr_run, 1'b1);
    check("rst_kb_irq", kb_irq, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // BRAM write/read and address aliasing
    bram_access(1'b1, 16'h3000, 16'h1234, 16'h0000, "wr3000");
    bram_access(1'b0, 16'h3000, 16'h0000, 16'h1234, "rd3000");
    bram_access(1'b1, 16'h4005, 16'hBEEF, 16'h0000, "wr4005");
    bram_access(1'b0, 16'h0005, 16'h0000, 16'hBEEF, "rd0005");

    // Keyboard
    @(negedge clk);
    kb_valid = 1'b1; kb_data = 8'h41;
    @(negedge clk);
    check("kb_ready_full", kb_ready, 1'b0);
    kb_valid = 1'b0;
    io_access(1'b0, 16'hFE00, 16'h0000, 16'h8000, "kbsr_full");
    io_access(1'b0, 16'hFE02, 16'h0000, 16'h0041, "kbdr_41");
    io_access(1'b0, 16'hFE00, 16'h0000, 16'h0000, "kbsr_empty");
    check("kb_ready_empty", kb_ready, 1'b1);
    @(negedge clk);
    kb_valid = 1'b1; kb_data = 8'h42;
    @(negedge clk);
    kb_valid = 1'b0;
    io_access(1'b1, 16'hFE00, 16'h4000, 16'h0000, "kbsr_ie");
    check("kb_irq_set", kb_irq, 1'b1);
    io_access(1'b0, 16'hFE00, 16'h0000, 16'hC000, "kbsr_ie_full");

    // Key offered in the same cycle KBDR is read is taken one cycle later
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFE02; kb_valid = 1'b1; kb_data = 8'h43;
    @(negedge clk);
    check("kbdr_42_rdy", cpu_ready, 1'b1);
    check("kbdr_42_data", cpu_rdata, 16'h0042);
    check("kb_ready_after_rd", kb_ready, 1'b1);
    cpu_req = 1'b0;
    @(negedge clk);
    check("kb_ready_took_43", kb_ready, 1'b0);
    kb_valid = 1'b0;
    io_access(1'b0, 16'hFE02, 16'h0000, 16'h0043, "kbdr_43");
    check("kb_irq_clear", kb_irq, 1'b0);
    io_access(1'b1, 16'hFE02, 16'h00AA, 16'h0000, "kbdr_wr_ign");
    io_access(1'b0, 16'hFE02, 16'h0000, 16'h0043, "kbdr_still_43");

    // Display
    io_access(1'b1, 16'hFE06, 16'h0058, 16'h0000, "ddr_58");
    check("dd_valid_set", dd_valid, 1'b1);
    check("dd_data_58", dd_data, 16'h0058);
    io_access(1'b0, 16'hFE04, 16'h0000, 16'h0000, "dsr_busy");
    io_access(1'b1, 16'hFE06, 16'h0059, 16'h0000, "ddr_59_drop");
    check("dd_data_kept", dd_data, 16'h0058);
    @(negedge clk);
    dd_ready = 1'b1;
    @(negedge clk);
    dd_ready = 1'b0;
    check("dd_valid_clr", dd_valid, 1'b0);
    io_access(1'b0, 16'hFE04, 16'h0000, 16'h8000, "dsr_idle");
    io_access(1'b0, 16'hFE06, 16'h0000, 16'h0058, "ddr_rd");

    // Unmapped I/O and MCR
    io_access(1'b0, 16'hFE10, 16'h0000, 16'h0000, "unmapped_rd");
    io_access(1'b1, 16'hFE10, 16'hFFFF, 16'h0000, "unmapped_wr");
    io_access(1'b1, 16'hFFFE, 16'h0000, 16'h0000, "mcr_wr0");
    check("mcr_run_0", mcr_run, 1'b0);
    io_access(1'b0, 16'hFE06, 16'h0000, 16'h0058, "ddr_rd2");
    io_access(1'b0, 16'hFFFE, 16'h0000, 16'h0000, "mcr_rd0");
    bram_access(1'b0, 16'h3000, 16'h0000, 16'h1234, "rd_halted");

    // Reset in ACC of a read
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
    @(negedge clk);
    rst_n = 1'b0; cpu_req = 1'b0;
    #1;
    check("rrd_ready", cpu_ready, 1'b0);
    check("rrd_rdata", cpu_rdata, 16'h0000);
    check("rrd_bram_addr", bram_addr, 16'h0000);
    check("rrd_mcr_run", mcr_run, 1'b1);
    check("rrd_kb_irq", kb_irq, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rrd_no_ready", cpu_ready, 1'b0);
    end

    // Reset in ACC of a write: strobe must drop and memory stays intact
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3000; cpu_wdata = 16'hDEAD;
    @(negedge clk);
    check("rwr_wr_high", bram_wr, 1'b1);
    rst_n = 1'b0; cpu_req = 1'b0;
    #1;
    check("rwr_wr_forced", bram_wr, 1'b0);
    check("rwr_din", bram_din, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rwr_no_ready", cpu_ready, 1'b0);

    bram_access(1'b0, 16'h3000, 16'h0000, 16'h1234, "rd_after_rst");
    io_access(1'b0, 16'hFFFE, 16'h0000, 16'h8000, "mcr_rd_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
